// File: rtl/sample_buffer_pkg.sv
// Shared constants for the sample storage FIFO: register map, control and
// status bit positions, and the stored entry layout.
package sample_buffer_pkg;

  localparam int DATA_W  = 16;
  localparam int TAG_W   = 4;
  localparam int ENTRY_W = TAG_W + DATA_W;

  localparam logic [7:0] REG_DATA     = 8'h00;
  localparam logic [7:0] REG_TAG      = 8'h01;
  localparam logic [7:0] REG_LEVEL    = 8'h02;
  localparam logic [7:0] REG_OVERFLOW = 8'h03;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_CONTROL  = 8'h05;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_HALF_FULL = 2;
  localparam int STAT_UNDERFLOW = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  unit;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [15:0] status_word(input logic underflow,
                                              input logic half_full,
                                              input logic full,
                                              input logic empty);
    logic [15:0] w;
    w                 = '0;
    w[STAT_UNDERFLOW] = underflow;
    w[STAT_HALF_FULL] = half_full;
    w[STAT_FULL]      = full;
    w[STAT_EMPTY]     = empty;
    return w;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port storage for the sample FIFO: one write port and one
// registered read port; contents are not reset.
module sample_ram
  import sample_buffer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = ENTRY_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_buffer.sv
// Tagged sample FIFO between the round-robin collector and the MCU, drained
// through a decoded EBI register window; drops and counts samples when full.
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int POSITION   = 0,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] addr,
  input  logic [15:0] ebi_data_in,
  output logic [15:0] ebi_data_out,
  input  logic        enable,
  input  logic        re,
  input  logic        wr,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic [3:0]  sample_unit,
  output logic        full,
  output logic        empty,
  output logic        half_full
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(2 ** DEPTH_LOG2);
  localparam logic [LW-1:0] LEVEL_HALF = LW'(2 ** (DEPTH_LOG2 - 1));

  logic                  sel, rd_req, wr_req;
  logic                  rd_prev, wr_prev, rd_evt, wr_evt;
  logic [7:0]            rd_off, wr_off;
  logic [1:0]            ctrl_bits;
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [LW-1:0]         level, level_next;
  logic [15:0]           overflow_cnt;
  logic                  underflow;
  logic                  flush, clear, pop_req, pop, push, drop, is_empty;
  logic [ENTRY_W-1:0]    head;
  entry_t                head_entry;
  logic                  unused_data_bits;

  assign sel              = enable && (addr[18:8] == 11'(POSITION));
  assign rd_req           = sel && re;
  assign wr_req           = sel && wr;
  assign head_entry       = head;
  assign unused_data_bits = ^ebi_data_in[15:2];

  // Strobes are levels of arbitrary length; only their rising edge counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev   <= 1'b0;
      wr_prev   <= 1'b0;
      rd_evt    <= 1'b0;
      wr_evt    <= 1'b0;
      rd_off    <= '0;
      wr_off    <= '0;
      ctrl_bits <= '0;
    end else begin
      rd_prev <= rd_req;
      wr_prev <= wr_req;
      rd_evt  <= rd_req && !rd_prev;
      wr_evt  <= wr_req && !wr_prev;
      if (rd_req && !rd_prev) begin
        rd_off <= addr[7:0];
      end
      if (wr_req && !wr_prev) begin
        wr_off    <= addr[7:0];
        ctrl_bits <= ebi_data_in[1:0];
      end
    end
  end

  always_comb begin
    is_empty   = (level == '0);
    flush      = wr_evt && (wr_off == REG_CONTROL) && ctrl_bits[CTRL_FLUSH];
    clear      = wr_evt && (wr_off == REG_CONTROL) && ctrl_bits[CTRL_CLEAR];
    pop_req    = rd_evt && (rd_off == REG_DATA);
    pop        = pop_req && !is_empty && !flush;
    push       = sample_valid && !flush && ((level != LEVEL_FULL) || pop);
    drop       = sample_valid && !flush && !push;
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      level_next = level + LW'(push) - LW'(pop);
    end
  end

  sample_ram #(
    .ADDR_W(DEPTH_LOG2),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wp),
    .wdata({sample_unit, sample_data}),
    .raddr(rp),
    .rdata(head)
  );

  // Flags come from level_next so they change on the same edge as level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      half_full <= 1'b0;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + DEPTH_LOG2'(1);
        if (pop)  rp <= rp + DEPTH_LOG2'(1);
      end
      level     <= level_next;
      empty     <= (level_next == '0);
      full      <= (level_next == LEVEL_FULL);
      half_full <= (level_next >= LEVEL_HALF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
      underflow    <= 1'b0;
    end else begin
      if (clear) begin
        overflow_cnt <= '0;
      end else if (drop && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
      if (clear) begin
        underflow <= 1'b0;
      end else if (pop_req && is_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Read data holds its value between read events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ebi_data_out <= '0;
    end else if (rd_evt) begin
      case (rd_off)
        REG_DATA:     ebi_data_out <= is_empty ? 16'h0000 : head_entry.data;
        REG_TAG:      ebi_data_out <= {12'h000, head_entry.unit};
        REG_LEVEL:    ebi_data_out <= 16'(level);
        REG_OVERFLOW: ebi_data_out <= overflow_cnt;
        REG_STATUS:   ebi_data_out <= status_word(underflow, half_full, full, empty);
        default:      ebi_data_out <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_buffer.sv
// Randomized bench for sample_buffer at depth 16, checked against a queue
// model of the FIFO, its overflow counter and sticky underflow.
module tb_sample_buffer;
  import sample_buffer_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int POS   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] addr;
  logic [15:0] ebi_data_in, ebi_data_out;
  logic        enable, re, wr, sample_valid;
  logic [15:0] sample_data;
  logic [3:0]  sample_unit;
  logic        full, empty, half_full;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [19:0] model_q[$];
  int          model_ovf;
  bit          model_under;

  always #5 clk = ~clk;

  sample_buffer #(.POSITION(POS), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ebi_data_in(ebi_data_in),
    .ebi_data_out(ebi_data_out), .enable(enable), .re(re), .wr(wr),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_unit(sample_unit), .full(full), .empty(empty), .half_full(half_full)
  );

  // ---------------- reference model ----------------
  function automatic void model_reset();
    model_q.delete();
    model_ovf   = 0;
    model_under = 0;
  endfunction

  function automatic void model_push(input logic [15:0] d, input logic [3:0] u);
    if (model_q.size() < DEPTH) model_q.push_back({u, d});
    else if (model_ovf < 65535) model_ovf++;
  endfunction

  function automatic logic [15:0] model_read(input logic [7:0] off);
    logic [19:0] e;
    case (off)
      8'h00: begin
        if (model_q.size() == 0) begin
          model_under = 1;
          return 16'h0000;
        end
        e = model_q.pop_front();
        return e[15:0];
      end
      8'h01: begin
        if (model_q.size() == 0) return 16'h0000;
        e = model_q[0];
        return {12'h000, e[19:16]};
      end
      8'h02: return 16'(model_q.size());
      8'h03: return 16'(model_ovf);
      8'h04: return {12'h000, model_under, model_q.size() >= DEPTH / 2,
                     model_q.size() == DEPTH, model_q.size() == 0};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void model_write(input logic [7:0] off, input logic [15:0] d);
    if (off == 8'h05) begin
      if (d[0]) model_q.delete();
      if (d[1]) begin
        model_ovf   = 0;
        model_under = 0;
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic ebi_read(input int win, input logic [7:0] off, input int hold,
                          output logic [15:0] data);
    @(negedge clk);
    addr = {11'(win), off}; enable = 1'b1; re = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data = ebi_data_out;
    for (int i = 2; i < hold; i++) @(negedge clk);
    re = 1'b0; enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ebi_write(input logic [7:0] off, input logic [15:0] d);
    @(negedge clk);
    addr = {11'(POS), off}; enable = 1'b1; wr = 1'b1; ebi_data_in = d;
    @(negedge clk);
    @(negedge clk);
    wr = 1'b0; enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_write(off, d);
  endtask

  task automatic push_sample(input logic [15:0] d, input logic [3:0] u);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = d; sample_unit = u;
    @(negedge clk);
    sample_valid = 1'b0;
    model_push(d, u);
  endtask

  task automatic push_random();
    push_sample(16'($urandom), 4'($urandom_range(0, 9)));
  endtask

  // Lands sample_valid on the same edge as the DATA pop.
  task automatic pop_with_push(input logic [15:0] d, input logic [3:0] u,
                               output logic [15:0] got);
    @(negedge clk);
    addr = {11'(POS), REG_DATA}; enable = 1'b1; re = 1'b1;
    @(negedge clk);
    sample_valid = 1'b1; sample_data = d; sample_unit = u;
    @(negedge clk);
    sample_valid = 1'b0; re = 1'b0; enable = 1'b0;
    got = ebi_data_out;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] got, exp;
    repeat (3) @(negedge clk);
    n_cmp++; if (ebi_data_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_data_out: got %h want 0000", ebi_data_out); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (half_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_half_full: got %b want 0", half_full); end
    rst = 1'b0;
    ebi_read(POS, REG_STATUS, 2, got); exp = model_read(REG_STATUS);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL reset_status: got %h want %h", got, exp); end
  endtask

  task automatic test_basic();
    logic [15:0] got, exp;
    push_sample(16'h1111, 4'd2);
    push_sample(16'h2222, 4'd5);
    push_sample(16'h3333, 4'd9);
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL basic_level3: got %h want %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      ebi_read(POS, REG_TAG, 2, got); exp = model_read(REG_TAG);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL basic_tag[%0d]: got %h want %h", i, got, exp); end
      ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", i, got, exp); end
    end
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL basic_level0: got %h want %h", got, exp); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    logic [15:0] got, exp;
    for (int i = 0; i < 20; i++) begin
      push_random();
      n_cmp++; if (full !== (model_q.size() == DEPTH)) begin n_fail++; $display("[TB] FAIL ovf_full[%0d]: got %b want %b", i, full, model_q.size() == DEPTH); end
      n_cmp++; if (half_full !== (model_q.size() >= DEPTH / 2)) begin n_fail++; $display("[TB] FAIL ovf_half[%0d]: got %b want %b", i, half_full, model_q.size() >= DEPTH / 2); end
    end
    ebi_read(POS, REG_OVERFLOW, 2, got); exp = model_read(REG_OVERFLOW);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL ovf_count: got %h want %h", got, exp); end
    for (int i = 0; i < DEPTH; i++) begin
      ebi_read(POS, REG_TAG, 2, got); exp = model_read(REG_TAG);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL ovf_tag[%0d]: got %h want %h", i, got, exp); end
      ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL ovf_data[%0d]: got %h want %h", i, got, exp); end
    end
    ebi_write(REG_CONTROL, 16'h0002);
    ebi_read(POS, REG_OVERFLOW, 2, got); exp = model_read(REG_OVERFLOW);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL ovf_cleared: got %h want %h", got, exp); end
  endtask

  task automatic test_underflow();
    logic [15:0] got, exp;
    ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL under_data: got %h want %h", got, exp); end
    ebi_read(POS, REG_STATUS, 2, got); exp = model_read(REG_STATUS);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL under_status: got %h want %h", got, exp); end
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL under_level: got %h want %h", got, exp); end
    push_random();
    ebi_read(POS, REG_TAG, 2, got); exp = model_read(REG_TAG);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL under_tag_after: got %h want %h", got, exp); end
    ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL under_data_after: got %h want %h", got, exp); end
    ebi_write(REG_CONTROL, 16'h0002);
    ebi_read(POS, REG_STATUS, 2, got); exp = model_read(REG_STATUS);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL under_cleared: got %h want %h", got, exp); end
  endtask

  task automatic test_coincident_full();
    logic [15:0] got, exp, d;
    logic [3:0]  u;
    while (model_q.size() < DEPTH) push_random();
    d = 16'($urandom); u = 4'($urandom_range(0, 9));
    pop_with_push(d, u, got);
    exp = model_read(REG_DATA);
    model_push(d, u);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL cofull_data: got %h want %h", got, exp); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL cofull_flag: got %b want 1", full); end
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL cofull_level: got %h want %h", got, exp); end
    ebi_read(POS, REG_OVERFLOW, 2, got); exp = model_read(REG_OVERFLOW);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL cofull_ovf: got %h want %h", got, exp); end
    for (int i = 0; i < DEPTH; i++) begin
      ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL cofull_drain[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_coincident_empty();
    logic [15:0] got, exp, d;
    logic [3:0]  u;
    d = 16'($urandom); u = 4'($urandom_range(0, 9));
    pop_with_push(d, u, got);
    exp = model_read(REG_DATA);
    model_push(d, u);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL coempty_data: got %h want %h", got, exp); end
    ebi_read(POS, REG_STATUS, 2, got); exp = model_read(REG_STATUS);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL coempty_status: got %h want %h", got, exp); end
    ebi_read(POS, REG_TAG, 2, got); exp = model_read(REG_TAG);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL coempty_tag: got %h want %h", got, exp); end
    ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL coempty_drain: got %h want %h", got, exp); end
    ebi_write(REG_CONTROL, 16'h0002);
  endtask

  task automatic test_long_strobe();
    logic [15:0] got, exp;
    repeat (3) push_random();
    ebi_read(POS, REG_DATA, 10, got); exp = model_read(REG_DATA);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL long_data: got %h want %h", got, exp); end
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL long_level: got %h want %h", got, exp); end
    while (model_q.size() > 0) begin
      ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL long_drain: got %h want %h", got, exp); end
    end
  endtask

  task automatic test_window();
    logic [15:0] got, exp;
    push_random();
    ebi_read(POS + 1, REG_DATA, 2, got);
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL window_level: got %h want %h", got, exp); end
    ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL window_data: got %h want %h", got, exp); end
    ebi_read(POS, 8'h17, 2, got); exp = model_read(8'h17);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL window_unmapped: got %h want %h", got, exp); end
  endtask

  task automatic test_flush();
    logic [15:0] got, exp;
    repeat (5) push_random();
    ebi_write(REG_CONTROL, 16'h0001);
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL flush_level: got %h want %h", got, exp); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_empty: got %b want 1", empty); end
    repeat (2) push_random();
    for (int i = 0; i < 2; i++) begin
      ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL flush_after[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_flush_vs_push();
    logic [15:0] got, exp;
    while (model_q.size() < DEPTH) push_random();
    @(negedge clk);
    addr = {11'(POS), REG_CONTROL}; enable = 1'b1; wr = 1'b1; ebi_data_in = 16'h0001;
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 16'($urandom); sample_unit = 4'd7;
    @(negedge clk);
    sample_valid = 1'b0; wr = 1'b0; enable = 1'b0;
    @(negedge clk);
    model_write(REG_CONTROL, 16'h0001);
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL fvp_level: got %h want %h", got, exp); end
    ebi_read(POS, REG_OVERFLOW, 2, got); exp = model_read(REG_OVERFLOW);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL fvp_ovf: got %h want %h", got, exp); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL fvp_full: got %b want 0", full); end
  endtask

  task automatic test_wrap();
    logic [15:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      push_random();
      ebi_read(POS, REG_TAG, 2, got); exp = model_read(REG_TAG);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL wrap_tag[%0d]: got %h want %h", i, got, exp); end
      ebi_read(POS, REG_DATA, 2, got); exp = model_read(REG_DATA);
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL wrap_data[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic [7:0]  off;
    int          r;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        push_random();
      end else begin
        case (r)
          5, 6:    off = REG_DATA;
          7:       off = REG_LEVEL;
          8:       off = REG_STATUS;
          default: off = (model_q.size() > 0) ? REG_TAG : REG_OVERFLOW;
        endcase
        ebi_read(POS, off, 2, got); exp = model_read(off);
        n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL random[%0d] off %h: got %h want %h", i, off, got, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp;
    while (model_q.size() < DEPTH) push_random();
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL mid_level_pre: got %h want %h", got, exp); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ebi_data_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_data_out: got %h want 0000", ebi_data_out); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_full: got %b want 0", full); end
    n_cmp++; if (half_full !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_half: got %b want 0", half_full); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ebi_read(POS, REG_LEVEL, 2, got); exp = model_read(REG_LEVEL);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL mid_level_post: got %h want %h", got, exp); end
    ebi_read(POS, REG_STATUS, 2, got); exp = model_read(REG_STATUS);
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL mid_status_post: got %h want %h", got, exp); end
  endtask

  initial begin
    rst = 1'b1; addr = '0; ebi_data_in = '0; enable = 1'b0; re = 1'b0; wr = 1'b0;
    sample_valid = 1'b0; sample_data = '0; sample_unit = '0;
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_coincident_full();
    test_coincident_empty();
    test_long_strobe();
    test_window();
    test_flush();
    test_flush_vs_push();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
